axi_ar_xbar: RTL and testbench



---
 rtl/axi_ar_xbar.sv | 211 +++++++++++++++++++++
 tb/tb_axi_ar_xbar.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ar_xbar.sv
// ---------------------------------------------------------------------------
// axi_ar_xbar
//   Read-address (AR) channel crossbar. It round-robin arbitrates NUM_M
//   masters, decodes the winning address against a BASE/MASK region table,
//   and presents the registered request to exactly one of NUM_S+1 slaves.
//   Slave NUM_S is the default slave (SD) for unmapped addresses. Each master
//   is limited to MAX_OUT outstanding reads, tracked by RDONE_M pulses.
//
// Ports
//   clk, rst           : clock (rising edge), synchronous active-low reset
//   ARID_M..ARBURST_M  : per-master AR fields, master i at slice i
//   ARVALID_M/ARREADY_M: per-master AR handshake
//   RDONE_M            : per-master pulse, last R beat of a read completed
//   ARID_S..ARBURST_S  : registered AR fields broadcast to all slaves;
//                        ARID_S = {master index, ARID}
//   ARVALID_S/ARREADY_S: per-slave handshake, bit NUM_S is the default slave
// ---------------------------------------------------------------------------
module axi_ar_xbar #(
  parameter int unsigned NUM_M     = 2,
  parameter int unsigned NUM_S     = 6,
  parameter int unsigned ID_BITS   = 4,
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned LEN_BITS  = 4,
  parameter int unsigned SIZE_BITS = 3,
  parameter int unsigned MAX_OUT   = 4,
  parameter logic [ADDR_BITS-1:0] BASE [NUM_S] = '{
    32'h0000_0000, 32'h0001_0000, 32'h0002_0000,
    32'h0003_0000, 32'h0004_0000, 32'h0005_0000},
  parameter logic [ADDR_BITS-1:0] MASK [NUM_S] = '{default: 32'hFFFF_0000},
  localparam int unsigned MI_BITS  = $clog2(NUM_M),
  localparam int unsigned IDS_BITS = ID_BITS + MI_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_M*ID_BITS-1:0]   ARID_M,
  input  logic [NUM_M*ADDR_BITS-1:0] ARADDR_M,
  input  logic [NUM_M*LEN_BITS-1:0]  ARLEN_M,
  input  logic [NUM_M*SIZE_BITS-1:0] ARSIZE_M,
  input  logic [NUM_M*2-1:0]         ARBURST_M,
  input  logic [NUM_M-1:0]           ARVALID_M,
  output logic [NUM_M-1:0]           ARREADY_M,
  input  logic [NUM_M-1:0]           RDONE_M,
  output logic [IDS_BITS-1:0]        ARID_S,
  output logic [ADDR_BITS-1:0]       ARADDR_S,
  output logic [LEN_BITS-1:0]        ARLEN_S,
  output logic [SIZE_BITS-1:0]       ARSIZE_S,
  output logic [1:0]                 ARBURST_S,
  output logic [NUM_S:0]             ARVALID_S,
  input  logic [NUM_S:0]             ARREADY_S
);

  localparam int unsigned CNT_BITS = $clog2(MAX_OUT + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               state, state_nxt;
  logic [MI_BITS-1:0]   rr_ptr;
  logic [CNT_BITS-1:0]  out_cnt [NUM_M];
  logic [NUM_S:0]       tgt_oh;

  logic [NUM_M-1:0]     eligible;
  logic                 grant_vld;
  logic [MI_BITS-1:0]   grant_idx;
  logic                 hs;

  logic [ID_BITS-1:0]   sel_id;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [LEN_BITS-1:0]  sel_len;
  logic [SIZE_BITS-1:0] sel_size;
  logic [1:0]           sel_burst;
  logic [NUM_S:0]       dec_oh;

  logic [NUM_M-1:0]     cnt_inc;
  logic [NUM_M-1:0]     cnt_dec;

  // A master at its outstanding limit is simply not eligible, so the search
  // passes over it and rr_ptr is only moved by an actual grant.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      eligible[i] = ARVALID_M[i] && (out_cnt[i] < CNT_BITS'(MAX_OUT));
    end
  end

  always_comb begin : arb
    int unsigned idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_M) begin
        idx = idx - NUM_M;
      end
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx[MI_BITS-1:0];
      end
    end
  end

  always_comb begin
    sel_id    = '0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (grant_idx == MI_BITS'(i)) begin
        sel_id    = ARID_M[i*ID_BITS +: ID_BITS];
        sel_addr  = ARADDR_M[i*ADDR_BITS +: ADDR_BITS];
        sel_len   = ARLEN_M[i*LEN_BITS +: LEN_BITS];
        sel_size  = ARSIZE_M[i*SIZE_BITS +: SIZE_BITS];
        sel_burst = ARBURST_M[i*2 +: 2];
      end
    end
  end

  // Lowest-numbered matching region wins; no match routes to the default slave.
  always_comb begin : decode
    logic found;
    dec_oh = '0;
    found  = 1'b0;
    for (int unsigned j = 0; j < NUM_S; j++) begin
      if (!found && ((sel_addr & MASK[j]) == BASE[j])) begin
        dec_oh[j] = 1'b1;
        found     = 1'b1;
      end
    end
    if (!found) begin
      dec_oh[NUM_S] = 1'b1;
    end
  end

  // ARREADY_M is gated by rst so no handshake can be accepted while reset is
  // being applied, even though the state register only clears at the edge.
  always_comb begin
    state_nxt = state;
    hs        = 1'b0;
    ARREADY_M = '0;
    ARVALID_S = '0;
    case (state)
      IDLE: begin
        if (rst && grant_vld) begin
          hs                   = 1'b1;
          ARREADY_M[grant_idx] = 1'b1;
          state_nxt            = HOLD;
        end
      end
      HOLD: begin
        ARVALID_S = tgt_oh;
        if ((ARREADY_S & tgt_oh) != '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr    <= '0;
      tgt_oh    <= '0;
      ARID_S    <= '0;
      ARADDR_S  <= '0;
      ARLEN_S   <= '0;
      ARSIZE_S  <= '0;
      ARBURST_S <= '0;
    end else if (hs) begin
      rr_ptr    <= (grant_idx == MI_BITS'(NUM_M - 1)) ? '0 : grant_idx + MI_BITS'(1);
      tgt_oh    <= dec_oh;
      ARID_S    <= {grant_idx, sel_id};
      ARADDR_S  <= sel_addr;
      ARLEN_S   <= sel_len;
      ARSIZE_S  <= sel_size;
      ARBURST_S <= sel_burst;
    end
  end

  // A completion at zero outstanding is dropped; grant and completion in the
  // same cycle cancel.
  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      cnt_inc[i] = hs && (grant_idx == MI_BITS'(i));
      cnt_dec[i] = RDONE_M[i] && (out_cnt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (!rst) begin
        out_cnt[i] <= '0;
      end else if (cnt_inc[i] && !cnt_dec[i]) begin
        out_cnt[i] <= out_cnt[i] + CNT_BITS'(1);
      end else if (cnt_dec[i] && !cnt_inc[i]) begin
        out_cnt[i] <= out_cnt[i] - CNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_ar_xbar.sv
// ---------------------------------------------------------------------------
// tb_axi_ar_xbar
//   Randomized bench for axi_ar_xbar. A behavioural model tracks whether a
//   request is being presented, its fields and target, the round-robin start
//   point and per-master outstanding counts, and predicts every output each
//   cycle from the arbitration/decode rules.
// ---------------------------------------------------------------------------
module tb_axi_ar_xbar;

  localparam int NM  = 2;
  localparam int NS  = 6;
  localparam int IDB = 4;
  localparam int AB  = 32;
  localparam int LB  = 4;
  localparam int SB  = 3;
  localparam int MO  = 4;
  localparam int IDS = IDB + 1;

  // Region 5 overlaps regions 0..4, so lowest-index priority is exercised.
  localparam logic [AB-1:0] TB_BASE [NS] = '{
    32'h0000_0000, 32'h0001_0000, 32'h0002_0000,
    32'h0003_0000, 32'h0004_0000, 32'h0000_0000};
  localparam logic [AB-1:0] TB_MASK [NS] = '{
    32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
    32'hFFFF_0000, 32'hFFFF_0000, 32'hFFF0_0000};

  logic              clk;
  logic              rst;
  logic [NM*IDB-1:0] ARID_M;
  logic [NM*AB-1:0]  ARADDR_M;
  logic [NM*LB-1:0]  ARLEN_M;
  logic [NM*SB-1:0]  ARSIZE_M;
  logic [NM*2-1:0]   ARBURST_M;
  logic [NM-1:0]     ARVALID_M;
  logic [NM-1:0]     ARREADY_M;
  logic [NM-1:0]     RDONE_M;
  logic [IDS-1:0]    ARID_S;
  logic [AB-1:0]     ARADDR_S;
  logic [LB-1:0]     ARLEN_S;
  logic [SB-1:0]     ARSIZE_S;
  logic [1:0]        ARBURST_S;
  logic [NS:0]       ARVALID_S;
  logic [NS:0]       ARREADY_S;

  axi_ar_xbar #(
    .NUM_M(NM), .NUM_S(NS), .ID_BITS(IDB), .ADDR_BITS(AB),
    .LEN_BITS(LB), .SIZE_BITS(SB), .MAX_OUT(MO),
    .BASE(TB_BASE), .MASK(TB_MASK)
  ) dut (
    .clk(clk), .rst(rst),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M),
    .ARSIZE_M(ARSIZE_M), .ARBURST_M(ARBURST_M),
    .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M), .RDONE_M(RDONE_M),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
    .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
    .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model state
  bit             m_busy;
  int             m_rr;
  int             m_cnt [NM];
  int             m_tgt;
  logic [IDS-1:0] m_id;
  logic [AB-1:0]  m_addr;
  logic [LB-1:0]  m_len;
  logic [SB-1:0]  m_size;
  logic [1:0]     m_burst;
  int             n_grants = 0;

  task automatic model_reset();
    m_busy  = 1'b0;
    m_rr    = 0;
    m_tgt   = 0;
    m_id    = '0;
    m_addr  = '0;
    m_len   = '0;
    m_size  = '0;
    m_burst = '0;
    for (int i = 0; i < NM; i++) m_cnt[i] = 0;
  endtask

  function automatic int decode(input logic [AB-1:0] a);
    for (int j = 0; j < NS; j++) begin
      if ((a & TB_MASK[j]) == TB_BASE[j]) return j;
    end
    return NS;
  endfunction

  function automatic int pick_winner();
    for (int k = 0; k < NM; k++) begin
      int idx;
      idx = (m_rr + k) % NM;
      if (ARVALID_M[idx] && m_cnt[idx] < MO) return idx;
    end
    return -1;
  endfunction

  function automatic logic [AB-1:0] rand_addr();
    logic [AB-1:0] a;
    int r;
    r = int'($urandom_range(7));
    a = AB'($urandom_range(16'hFFFF));
    case (r)
      0, 1, 2, 3, 4: a = a | (AB'(r) << 16);
      5:             a = a | 32'h000A_0000;
      6:             a = a | 32'hFFFF_0000;
      default:       a = AB'($urandom);
    endcase
    return a;
  endfunction

  task automatic drive(input int p_valid, input int p_ready, input int p_rdone,
                       input int p_rst, input bit fixed_id);
    rst = !(int'($urandom_range(99)) < p_rst);
    for (int i = 0; i < NM; i++) begin
      ARVALID_M[i] = int'($urandom_range(99)) < p_valid;
      RDONE_M[i]   = int'($urandom_range(99)) < p_rdone;
      ARID_M[i*IDB +: IDB]  = fixed_id ? IDB'(i * 3) : IDB'($urandom);
      ARADDR_M[i*AB +: AB]  = fixed_id ? ((i == 0) ? 32'h0001_0000 : 32'hFFFF_0000)
                                       : rand_addr();
      ARLEN_M[i*LB +: LB]   = LB'($urandom);
      ARSIZE_M[i*SB +: SB]  = SB'($urandom);
      ARBURST_M[i*2 +: 2]   = 2'($urandom);
    end
    for (int j = 0; j <= NS; j++) begin
      ARREADY_S[j] = int'($urandom_range(99)) < p_ready;
    end
  endtask

  // Inputs are already applied (posedge + 1). Check mid-cycle, then advance
  // the model across the next rising edge.
  task automatic run_cycle();
    int w;
    logic [NM-1:0] er;
    logic [NS:0]   ev;
    bit hs;
    #4;
    w  = pick_winner();
    er = '0;
    ev = '0;
    if (rst && !m_busy && w >= 0) er[w] = 1'b1;
    if (m_busy) ev[m_tgt] = 1'b1;
    check("arready_m", 64'(ARREADY_M), 64'(er));
    check("arvalid_s", 64'(ARVALID_S), 64'(ev));
    check("arid_s",    64'(ARID_S),    64'(m_id));
    check("araddr_s",  64'(ARADDR_S),  64'(m_addr));
    check("arlen_s",   64'(ARLEN_S),   64'(m_len));
    check("arsize_s",  64'(ARSIZE_S),  64'(m_size));
    check("arburst_s", 64'(ARBURST_S), 64'(m_burst));
    if (!rst) begin
      model_reset();
    end else begin
      hs = !m_busy && (w >= 0);
      for (int i = 0; i < NM; i++) begin
        int inc, dec;
        inc = (hs && w == i) ? 1 : 0;
        dec = (RDONE_M[i] && m_cnt[i] > 0) ? 1 : 0;
        m_cnt[i] = m_cnt[i] + inc - dec;
      end
      if (hs) begin
        m_id    = IDS'(w << IDB) | IDS'(ARID_M[w*IDB +: IDB]);
        m_addr  = ARADDR_M[w*AB +: AB];
        m_len   = ARLEN_M[w*LB +: LB];
        m_size  = ARSIZE_M[w*SB +: SB];
        m_burst = ARBURST_M[w*2 +: 2];
        m_tgt   = decode(m_addr);
        m_rr    = (w + 1) % NM;
        m_busy  = 1'b1;
        n_grants++;
      end else if (m_busy && ARREADY_S[m_tgt]) begin
        m_busy = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic phase(input int cycles, input int p_valid, input int p_ready,
                       input int p_rdone, input int p_rst, input bit fixed_id);
    for (int c = 0; c < cycles; c++) begin
      drive(p_valid, p_ready, p_rdone, p_rst, fixed_id);
      run_cycle();
    end
  endtask

  initial begin
    rst       = 1'b0;
    ARID_M    = '0;
    ARADDR_M  = '0;
    ARLEN_M   = '0;
    ARSIZE_M  = '0;
    ARBURST_M = '0;
    ARVALID_M = '0;
    RDONE_M   = '0;
    ARREADY_S = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    // Reset held: outputs must read as the reset values.
    phase(3, 100, 100, 0, 100, 1'b0);
    // Both masters valid, every slave ready, no completions: alternating
    // grants, M1 ID 3 -> 0x13, then both saturate at the outstanding limit.
    phase(30, 100, 100, 0, 0, 1'b1);
    // Completions trickle in while both still request.
    phase(40, 100, 100, 20, 0, 1'b1);
    // General traffic, completions including some at zero outstanding.
    phase(400, 70, 50, 30, 0, 1'b0);
    // Slow slaves (long holds) and occasional reset, often during a hold.
    phase(400, 90, 15, 15, 3, 1'b0);
    // Heavy load, few completions: saturation and skipping.
    phase(300, 100, 60, 8, 0, 1'b0);
    // Mixed everything.
    phase(800, 60, 50, 25, 1, 1'b0);
    check("grants_seen", 64'(n_grants > 200), 64'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
